ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
Consumes the byte stream produced by the PS/2 receiver (rx_done_tick / rx_data) and converts Set-2 scan-code sequences into single key events. Each event carries make/break and extended flags. Events are queued in a small first-word-fall-through FIFO for the host logic. The block also tracks shift-key state and filters non-key device responses (ACK, BAT, echo, resend, error bytes).

Parameters:
FIFO_DEPTH, 4, event queue depth; power of 2, minimum 2
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
rx_done_tick  input  1  one-cycle strobe: rx_data holds a new received byte
rx_data  input  8  byte from PS/2 receiver, valid only with rx_done_tick
rd_en  input  1  pop head event; ignored when key_valid=0
clr_ovf  input  1  clears overflow
key_valid  output  1  FIFO non-empty
key_code  output  8  head event scan code (0x00 when empty)
key_ext  output  1  head event was E0-prefixed
key_break  output  1  head event is a release (F0-prefixed)
shift_held  output  1  left (0x12) or right (0x59) shift currently held
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous): FSM->IDLE, skip counter=0, FIFO empty, shift flags=0, overflow=0. All outputs 0. Reset mid-sequence discards any partial prefix.
- Bytes are processed only on cycles with rx_done_tick=1. Other cycles hold decode state.
- Filtered bytes in IDLE: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF. Each is consumed with no event and FSM stays IDLE.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0, SKIP_E1.
- IDLE transitions:
  - 0xE0 -> PRE_E0
  - 0xF0 -> PRE_F0
  - 0xE1 -> SKIP_E1, skip counter=7
  - filtered byte -> IDLE, no event
  - any other code -> push {ext=0, brk=0, code}
- PRE_E0 transitions:
  - 0xF0 -> PRE_E0F0
  - 0xE0 -> stay PRE_E0
  - 0x12 (fake shift) -> IDLE, no event
  - other -> push {ext=1, brk=0, code}, IDLE
- PRE_F0 transitions:
  - 0xE0, 0xF0 or 0xE1 -> IDLE, no event (protocol error)
  - other -> push {ext=0, brk=1, code}, IDLE
- PRE_E0F0 transitions:
  - 0x12 -> IDLE, no event
  - 0xE0, 0xF0 or 0xE1 -> IDLE, no event
  - other -> push {ext=1, brk=1, code}, IDLE
- SKIP_E1 (Pause sequence):
  - Each byte decrements the counter; contents are not checked.
  - On the byte that brings the counter to 0: push {ext=1, brk=0, code=0xE1}, then IDLE.
- Shift tracking:
  - Non-extended make of 0x12 sets lshift; non-extended make of 0x59 sets rshift.
  - Matching non-extended break clears the flag.
  - shift_held = lshift | rshift, registered, valid the cycle after the byte.
  - Shift tracking is updated even if the event is dropped for overflow.
- FIFO: 10-bit entries {ext, brk, code}; registered pointers; count is ADDR_W+1 bits.
- Output timing:
  - key_valid and head fields update the cycle after the push (rx_done_tick cycle) when the FIFO was empty.
  - Head outputs are valid combinationally from the FIFO array; 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Push while full without pop: event dropped, overflow set (visible next cycle), FIFO contents unchanged.
- Push and pop in the same cycle:
  - Full: both occur; count unchanged; no overflow.
  - Empty: pop ignored, push occurs.
- rd_en while empty: no effect, no underflow.
- clr_ovf: clears overflow next cycle. If clr_ovf and a new overflow occur in the same cycle, overflow stays set (set wins).

Test Plan:
- Make then break: bytes 0x1C, then 0xF0 0x1C, with no reads -> two entries {0,0,0x1C}, {0,1,0x1C}; key_valid=1 one cycle after the first tick.
- Extended sequence: bytes E0 75, E0 F0 75 -> entries {1,0,0x75}, {1,1,0x75}. Print Screen E0 12 E0 7C E0 F0 7C E0 F0 12 -> only {1,0,0x7C}, {1,1,0x7C}.
- Filtering and Pause: bytes FA AA 1C -> single event 0x1C. Pause E1 14 77 E1 F0 14 F0 77 -> single event {1,0,0xE1}; FSM back in IDLE, and a following 0x1C decodes normally.
- Shift tracking: 12, 59, F0 12 -> shift_held=1 throughout; then F0 59 -> shift_held=0 one cycle after the final tick.
- Overflow: push 5 events without reads (FIFO_DEPTH=4) -> 4 stored, overflow=1. Pop all -> codes in order, key_valid=0, key_code=0x00. Pulse clr_ovf -> overflow=0. Push+pop same cycle at full -> count stays 4, overflow stays 0.
- Reset mid-operation: assert reset (low) after 0xF0 with 2 events queued -> all outputs 0 immediately. After release, byte 0x1C -> make event (not break).

Source files
------------

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scan_decoder: PS/2 Set-2 scan-code bytes to key events, FWFT queue,  |
// | shift-key tracking and device-response filtering.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       shift_held,
  output logic       overflow
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRE_E0   = 3'd1;
  localparam logic [2:0] S_PRE_F0   = 3'd2;
  localparam logic [2:0] S_PRE_E0F0 = 3'd3;
  localparam logic [2:0] S_SKIP_E1  = 3'd4;

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(FIFO_DEPTH);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [2:0]        r_skip_cnt;
  logic              w_push;
  logic [9:0]        w_ev;
  logic              w_skip_load;
  logic              w_skip_dec;
  logic              r_lshift;
  logic              r_rshift;
  logic              r_ovf;
  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;
  logic [9:0]        w_head;

  function automatic logic is_filtered(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rx_done_tick) begin
      case (r_state)
        S_IDLE: begin
          if      (rx_data == 8'hE0) w_state_nxt = S_PRE_E0;
          else if (rx_data == 8'hF0) w_state_nxt = S_PRE_F0;
          else if (rx_data == 8'hE1) w_state_nxt = S_SKIP_E1;
        end
        S_PRE_E0: begin
          if      (rx_data == 8'hF0) w_state_nxt = S_PRE_E0F0;
          else if (rx_data != 8'hE0) w_state_nxt = S_IDLE;
        end
        S_SKIP_E1: begin
          if (r_skip_cnt <= 3'd1) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Event word is {ext, brk, code}
  always_comb begin
    w_push      = 1'b0;
    w_ev        = 10'h000;
    w_skip_load = 1'b0;
    w_skip_dec  = 1'b0;
    if (rx_done_tick) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE1) w_skip_load = 1'b1;
          else if (!is_prefix(rx_data) && !is_filtered(rx_data)) begin
            w_push = 1'b1;
            w_ev   = {2'b00, rx_data};
          end
        end
        S_PRE_E0: begin
          if (rx_data != 8'hF0 && rx_data != 8'hE0 && rx_data != 8'h12) begin
            w_push = 1'b1;
            w_ev   = {2'b10, rx_data};
          end
        end
        S_PRE_F0: begin
          if (!is_prefix(rx_data)) begin
            w_push = 1'b1;
            w_ev   = {2'b01, rx_data};
          end
        end
        S_PRE_E0F0: begin
          if (!is_prefix(rx_data) && rx_data != 8'h12) begin
            w_push = 1'b1;
            w_ev   = {2'b11, rx_data};
          end
        end
        S_SKIP_E1: begin
          w_skip_dec = 1'b1;
          if (r_skip_cnt <= 3'd1) begin
            w_push = 1'b1;
            w_ev   = {2'b10, 8'hE1};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = rd_en & ~w_empty;
  // At full, a simultaneous pop frees the slot the write lands in
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_ev;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skip_cnt <= 3'd0;
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_skip_load)     r_skip_cnt <= 3'd7;
      else if (w_skip_dec) r_skip_cnt <= r_skip_cnt - 3'd1;

      // Shift state follows the key stream even when the event is dropped
      if (w_push && !w_ev[9]) begin
        if (w_ev[7:0] == 8'h12) r_lshift <= ~w_ev[8];
        if (w_ev[7:0] == 8'h59) r_rshift <= ~w_ev[8];
      end

      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;

      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign key_valid  = ~w_empty;
  assign key_code   = w_empty ? 8'h00 : w_head[7:0];
  assign key_break  = ~w_empty & w_head[8];
  assign key_ext    = ~w_empty & w_head[9];
  assign shift_held = r_lshift | r_rshift;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// Testbench for ps2_scan_decoder: directed byte sequences, expected events are
// queued at stimulus time and compared by a monitor on every pop.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       shift_held;
  logic       overflow;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  ps2_scan_decoder #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .shift_held(shift_held),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every pop presented to the DUT is compared against the scoreboard
  always @(negedge clk) begin
    if (reset && rd_en && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none", {key_ext, key_break, key_code});
      end else begin
        check("pop_event", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [9:0] ev(input logic ext, input logic brk, input logic [7:0] code);
    return {ext, brk, code};
  endfunction

  // Entered and left at posedge+1; byte is captured on the intervening edge
  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (key_valid && n < 16) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      n++;
    end
  endtask

  task automatic expect_drain(input string name, input int want);
    int n;
    drain(n);
    check(name, n, want);
    check({name, "_scoreboard_left"}, exp_q.size(), 0);
    check({name, "_empty_valid"}, {31'd0, key_valid}, 0);
    check({name, "_empty_code"}, {24'd0, key_code}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3;
    check("rst_outputs", {26'd0, key_valid, key_code, key_ext, key_break, shift_held, overflow}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Make then break
    send(8'h1C);
    check("make_valid_next_cycle", {31'd0, key_valid}, 1);
    check("make_head", {22'd0, key_ext, key_break, key_code}, {22'd0, ev(0, 0, 8'h1C)});
    send_seq('{8'hF0, 8'h1C});
    exp_q.push_back(ev(0, 0, 8'h1C));
    exp_q.push_back(ev(0, 1, 8'h1C));
    expect_drain("make_break", 2);

    // Extended keys and Print Screen
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    exp_q.push_back(ev(1, 0, 8'h75));
    exp_q.push_back(ev(1, 1, 8'h75));
    send_seq('{8'hE0, 8'h12, 8'hE0, 8'h7C, 8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12});
    exp_q.push_back(ev(1, 0, 8'h7C));
    exp_q.push_back(ev(1, 1, 8'h7C));
    expect_drain("extended", 4);

    // Filtering, Pause, then normal decode
    send_seq('{8'hFA, 8'hAA, 8'h1C});
    exp_q.push_back(ev(0, 0, 8'h1C));
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    exp_q.push_back(ev(1, 0, 8'hE1));
    send(8'h1C);
    exp_q.push_back(ev(0, 0, 8'h1C));
    expect_drain("filter_pause", 3);

    // Shift tracking
    send(8'h12);
    check("shift_l_make", {31'd0, shift_held}, 1);
    send(8'h59);
    check("shift_r_make", {31'd0, shift_held}, 1);
    send_seq('{8'hF0, 8'h12});
    check("shift_l_break", {31'd0, shift_held}, 1);
    send(8'hF0);
    check("shift_mid_prefix", {31'd0, shift_held}, 1);
    send(8'h59);
    check("shift_r_break", {31'd0, shift_held}, 0);
    exp_q.push_back(ev(0, 0, 8'h12));
    exp_q.push_back(ev(0, 0, 8'h59));
    exp_q.push_back(ev(0, 1, 8'h12));
    exp_q.push_back(ev(0, 1, 8'h59));
    expect_drain("shift_events", 4);

    // Overflow, clear priority, push+pop at full
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D});
    check("full_no_ovf", {31'd0, overflow}, 0);
    send(8'h2C);
    check("ovf_set", {31'd0, overflow}, 1);
    clr_ovf = 1'b1;
    send(8'h3C);
    clr_ovf = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 1);
    exp_q.push_back(ev(0, 0, 8'h15));
    exp_q.push_back(ev(0, 0, 8'h1D));
    exp_q.push_back(ev(0, 0, 8'h24));
    exp_q.push_back(ev(0, 0, 8'h2D));
    expect_drain("ovf_drain", 4);
    check("ovf_sticky", {31'd0, overflow}, 1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 0);
    send_seq('{8'h16, 8'h1E, 8'h26, 8'h25});
    exp_q.push_back(ev(0, 0, 8'h16));
    exp_q.push_back(ev(0, 0, 8'h1E));
    exp_q.push_back(ev(0, 0, 8'h26));
    exp_q.push_back(ev(0, 0, 8'h25));
    rd_en = 1'b1;
    send(8'h35);
    rd_en = 1'b0;
    exp_q.push_back(ev(0, 0, 8'h35));
    check("pushpop_full_no_ovf", {31'd0, overflow}, 0);
    expect_drain("pushpop_full", 4);

    // Asynchronous reset mid-sequence
    send_seq('{8'h1C, 8'h1B, 8'hF0});
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs", {26'd0, key_valid, key_code, key_ext, key_break, shift_held, overflow}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h1C);
    check("post_rst_break", {31'd0, key_break}, 0);
    exp_q.push_back(ev(0, 0, 8'h1C));
    expect_drain("post_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
